cp_imem: RTL and testbench

Instruction-memory responder for the control processor (CP). It serves the IF stage's per-cycle fetch address with a registered one-cycle read, matching the IF stage's BRAM-delay assumption. It also provides a host-side streaming loader that writes a program image into the memory. While a load is in progress, it holds the CP core and forces NOP fetch data.

---
 rtl/cp_imem_pkg.sv | 17 +
 rtl/cp_imem_if.sv | 28 ++
 rtl/cp_imem_ram.sv | 21 ++
 rtl/cp_imem.sv | 88 ++++++++
 tb/tb_cp_imem.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp_imem_pkg.sv
// Shared widths and loader state encoding for the CP instruction memory.
package cp_imem_pkg;

    localparam int DEF_CP_INS_WIDTH        = 24;
    localparam int DEF_CP_I_MEM_ADDR_WIDTH = 12;

    localparam logic [1:0] DEF_CP_IMEM_ST_IDLE = 2'd0;
    localparam logic [1:0] DEF_CP_IMEM_ST_LOAD = 2'd1;
    localparam logic [1:0] DEF_CP_IMEM_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = DEF_CP_IMEM_ST_IDLE,
        ST_LOAD = DEF_CP_IMEM_ST_LOAD,
        ST_DONE = DEF_CP_IMEM_ST_DONE
    } imem_state_e;

endpackage

// File: rtl/cp_imem_if.sv
// Fetch and host-loader signals between the CP/host side (master) and cp_imem (slave).
interface cp_imem_if #(
    parameter int INS_WIDTH  = 24,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] iIF_IMEM_Addr;
    logic [INS_WIDTH-1:0]  oIMEM_IF_Instruction;
    logic                  iLoad_Start;
    logic [ADDR_WIDTH-1:0] iLoad_Base_Addr;
    logic [ADDR_WIDTH:0]   iLoad_Count;
    logic                  iLoad_Valid;
    logic [INS_WIDTH-1:0]  iLoad_Data;
    logic                  oLoad_Ready;
    logic                  oLoad_Done;
    logic                  oCore_Hold;

    modport slave (
        input  iIF_IMEM_Addr, iLoad_Start, iLoad_Base_Addr, iLoad_Count,
               iLoad_Valid, iLoad_Data,
        output oIMEM_IF_Instruction, oLoad_Ready, oLoad_Done, oCore_Hold
    );

    modport master (
        output iIF_IMEM_Addr, iLoad_Start, iLoad_Base_Addr, iLoad_Count,
               iLoad_Valid, iLoad_Data,
        input  oIMEM_IF_Instruction, oLoad_Ready, oLoad_Done, oCore_Hold
    );
endinterface

// File: rtl/cp_imem_ram.sv
// Single write port, registered read-first read port; array has no reset so it maps to BRAM.
module cp_imem_ram #(
    parameter int INS_WIDTH  = 24,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [INS_WIDTH-1:0]  wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [INS_WIDTH-1:0]  rdata_q
);
    logic [INS_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end
endmodule

// File: rtl/cp_imem.sv
// CP instruction memory: one-cycle fetch port plus host streaming loader that holds the core.
// State | meaning: IDLE = serving fetches; LOAD = accepting host words; DONE = one-cycle completion pulse.
module cp_imem
    import cp_imem_pkg::*;
#(
    parameter int INS_WIDTH  = 24,
    parameter int ADDR_WIDTH = 10
) (
    input logic      iClk,
    input logic      iReset,
    cp_imem_if.slave bus
);
    imem_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic                  nop_q, nop_d;
    logic                  we;
    logic                  hold;
    logic [INS_WIDTH-1:0]  rdata;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        we      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.iLoad_Start) begin
                    if (bus.iLoad_Count != '0) begin
                        ptr_d   = bus.iLoad_Base_Addr;
                        rem_d   = bus.iLoad_Count;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.iLoad_Valid) begin
                    we    = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == (ADDR_WIDTH+1)'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign hold  = (state_q != ST_IDLE);
    assign nop_d = hold;

    // nop_q resets high so the fetch output is zero while reset is asserted,
    // without needing a reset on the BRAM read register.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            nop_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            nop_q   <= nop_d;
        end
    end

    cp_imem_ram #(
        .INS_WIDTH (INS_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (iClk),
        .we     (we),
        .waddr  (ptr_q),
        .wdata  (bus.iLoad_Data),
        .raddr  (bus.iIF_IMEM_Addr),
        .rdata_q(rdata)
    );

    assign bus.oIMEM_IF_Instruction = nop_q ? '0 : rdata;
    assign bus.oLoad_Ready          = (state_q == ST_LOAD);
    assign bus.oLoad_Done           = (state_q == ST_DONE);
    assign bus.oCore_Hold           = hold;
endmodule

// File: tb/tb_cp_imem.sv
// Bench for cp_imem: transaction-level reference model, table-driven fetch checks, random traffic.
module tb_cp_imem;
    localparam int W     = 24;
    localparam int AW    = 10;
    localparam int CW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cp_imem_if #(.INS_WIDTH(W), .ADDR_WIDTH(AW)) bus ();
    cp_imem #(.INS_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .iClk  (clk),
        .iReset(rst),
        .bus   (bus)
    );

    typedef struct {
        int          addr;
        logic [W-1:0] exp;
    } fvec_t;
    fvec_t tbl [24];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: a load is a queue of target addresses; memory is a plain array.
    logic [W-1:0] m_mem   [DEPTH];
    bit           m_known [DEPTH];
    int           q_addr[$];
    bit           m_load;
    bit           m_done;
    logic [W-1:0] m_out;
    bit           m_out_known;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        q_addr.delete();
        m_load      = 1'b0;
        m_done      = 1'b0;
        m_out       = '0;
        m_out_known = 1'b1;
    endfunction

    function automatic void model_edge();
        int a;
        int fa;
        fa = int'(bus.iIF_IMEM_Addr);
        if (m_load || m_done) begin
            m_out       = '0;
            m_out_known = 1'b1;
        end else begin
            m_out       = m_mem[fa];
            m_out_known = m_known[fa];
        end
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_load) begin
            if (bus.iLoad_Valid) begin
                a          = q_addr.pop_front();
                m_mem[a]   = bus.iLoad_Data;
                m_known[a] = 1'b1;
                if (q_addr.size() == 0) begin
                    m_load = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (bus.iLoad_Start) begin
            if (bus.iLoad_Count == '0) begin
                m_done = 1'b1;
            end else begin
                for (int i = 0; i < int'(bus.iLoad_Count); i++)
                    q_addr.push_back((int'(bus.iLoad_Base_Addr) + i) % DEPTH);
                m_load = 1'b1;
            end
        end
    endfunction

    function automatic void check_outputs();
        chk("ready", bus.oLoad_Ready, m_load);
        chk("done", bus.oLoad_Done, m_done);
        chk("hold", bus.oCore_Hold, m_load | m_done);
        if (m_out_known) chk("instr", bus.oIMEM_IF_Instruction, m_out);
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic run_load(input int base, input int count, input logic [W-1:0] dbase,
                            input bit toggle, input bit addr_data,
                            output int s_cyc, output int done_cyc, output int rdy_cnt);
        int k;
        bit was;
        bus.iLoad_Base_Addr = AW'(base);
        bus.iLoad_Count     = CW'(count);
        bus.iLoad_Start     = 1'b1;
        bus.iLoad_Valid     = 1'b0;
        step();
        s_cyc           = cyc;
        bus.iLoad_Start = 1'b0;
        done_cyc        = -1;
        rdy_cnt         = 0;
        k               = 0;
        if (bus.oLoad_Ready) rdy_cnt++;
        if (bus.oLoad_Done) done_cyc = cyc;
        for (int t = 0; t < 2 * count + 4 && done_cyc < 0; t++) begin
            bus.iLoad_Valid = toggle ? (t % 2 == 0) : 1'b1;
            bus.iLoad_Data  = addr_data ? 24'h5A0000 + W'((base + k) % DEPTH) : dbase + W'(k);
            was = m_load && bus.iLoad_Valid;
            step();
            if (was) k++;
            if (bus.oLoad_Ready) rdy_cnt++;
            if (bus.oLoad_Done) done_cyc = cyc;
        end
        bus.iLoad_Valid = 1'b0;
        chk("load_done_seen", done_cyc >= 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s, d, r;
        tbl[0]  = '{12'h010, 24'hA00001}; tbl[1]  = '{12'h011, 24'hA00002};
        tbl[2]  = '{12'h012, 24'hA00003}; tbl[3]  = '{12'h013, 24'hA00004};
        tbl[4]  = '{12'h100, 24'hB00001}; tbl[5]  = '{12'h101, 24'hB00002};
        tbl[6]  = '{12'h102, 24'hB00003}; tbl[7]  = '{12'h103, 24'h5A0103};
        tbl[8]  = '{12'h3FE, 24'hC00001}; tbl[9]  = '{12'h3FF, 24'hC00002};
        tbl[10] = '{12'h000, 24'hC00003}; tbl[11] = '{12'h001, 24'hC00004};
        tbl[12] = '{12'h300, 24'hE00001}; tbl[13] = '{12'h301, 24'hE00002};
        tbl[14] = '{12'h302, 24'hE00003}; tbl[15] = '{12'h050, 24'h5A0050};
        tbl[16] = '{12'h200, 24'hD00001}; tbl[17] = '{12'h201, 24'hD00002};
        tbl[18] = '{12'h202, 24'h5A0202}; tbl[19] = '{12'h203, 24'h5A0203};
        tbl[20] = '{12'h204, 24'h5A0204}; tbl[21] = '{12'h005, 24'h123456};
        tbl[22] = '{12'h3A0, 24'h5A03A0}; tbl[23] = '{12'h3EF, 24'h5A03EF};

        bus.iIF_IMEM_Addr   = '0;
        bus.iLoad_Start     = 1'b0;
        bus.iLoad_Base_Addr = '0;
        bus.iLoad_Count     = '0;
        bus.iLoad_Valid     = 1'b0;
        bus.iLoad_Data      = '0;
        model_reset();
        step();
        chk("rst_instr", bus.oIMEM_IF_Instruction, 0);
        chk("rst_hold", bus.oCore_Hold, 0);
        step();
        rst = 1'b0;
        step();

        // Full-depth load from a non-zero base: must wrap and touch every word once.
        run_load(12'h3F0, DEPTH, '0, 1'b0, 1'b1, s, d, r);
        chk("full_done_time", d, s + DEPTH);
        chk("full_ready_cycles", r, DEPTH);
        step();

        // Basic load.
        bus.iIF_IMEM_Addr = 10'h013;
        run_load(12'h010, 4, 24'hA00001, 1'b0, 1'b0, s, d, r);
        chk("basic_done_time", d, s + 4);
        chk("basic_ready_cycles", r, 4);
        step();
        chk("basic_hold_drop", bus.oCore_Hold, 0);

        // Backpressure with valid toggling 1,0,1,0,1.
        run_load(12'h100, 3, 24'hB00001, 1'b1, 1'b0, s, d, r);
        chk("bp_done_time", d, s + 5);
        step();

        // Wrap across the top of memory.
        run_load(DEPTH - 2, 4, 24'hC00001, 1'b0, 1'b0, s, d, r);
        chk("wrap_done_time", d, s + 4);
        step();

        // Zero count: immediate DONE, one hold cycle, no writes.
        run_load(12'h3A0, 0, 24'hFFFFFF, 1'b0, 1'b0, s, d, r);
        chk("zero_done_time", d, s);
        chk("zero_hold", bus.oCore_Hold, 1);
        step();
        chk("zero_hold_drop", bus.oCore_Hold, 0);

        // Start pulsed mid-load with a different base must be ignored.
        bus.iIF_IMEM_Addr   = 10'h013;
        bus.iLoad_Base_Addr = 10'h300;
        bus.iLoad_Count     = CW'(3);
        bus.iLoad_Start     = 1'b1;
        step();
        bus.iLoad_Start     = 1'b1;
        bus.iLoad_Base_Addr = 10'h050;
        bus.iLoad_Count     = CW'(5);
        bus.iLoad_Valid     = 1'b1;
        bus.iLoad_Data      = 24'hE00001;
        step();
        chk("nop_during_load", bus.oIMEM_IF_Instruction, 0);
        bus.iLoad_Start = 1'b0;
        bus.iLoad_Data  = 24'hE00002;
        step();
        bus.iLoad_Data  = 24'hE00003;
        step();
        chk("ign_done", bus.oLoad_Done, 1);
        bus.iLoad_Valid = 1'b0;
        step();
        chk("ign_hold_drop", bus.oCore_Hold, 0);

        // Single word at address 5, then asynchronous reset while idle.
        run_load(5, 1, 24'h123456, 1'b0, 1'b0, s, d, r);
        step();
        bus.iIF_IMEM_Addr = 10'h005;
        step();
        chk("pre_rst_fetch", bus.oIMEM_IF_Instruction, 24'h123456);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_instr", bus.oIMEM_IF_Instruction, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_fetch", bus.oIMEM_IF_Instruction, 24'h123456);

        // Reset after 2 of 5 words.
        bus.iLoad_Base_Addr = 10'h200;
        bus.iLoad_Count     = CW'(5);
        bus.iLoad_Start     = 1'b1;
        step();
        bus.iLoad_Start = 1'b0;
        bus.iLoad_Valid = 1'b1;
        bus.iLoad_Data  = 24'hD00001;
        step();
        bus.iLoad_Data  = 24'hD00002;
        step();
        bus.iLoad_Data  = 24'hD00003;
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("midload_rst_hold", bus.oCore_Hold, 0);
        chk("midload_rst_ready", bus.oLoad_Ready, 0);
        chk("midload_rst_done", bus.oLoad_Done, 0);
        chk("midload_rst_instr", bus.oIMEM_IF_Instruction, 0);
        step();
        bus.iLoad_Valid = 1'b0;
        rst = 1'b0;
        step();

        for (int i = 0; i < 24; i++) begin
            bus.iIF_IMEM_Addr = AW'(tbl[i].addr);
            step();
            chk($sformatf("tbl_fetch_%03h", tbl[i].addr), bus.oIMEM_IF_Instruction, tbl[i].exp);
        end

        // Random traffic: fetches, loads, stray starts, random valid.
        for (int i = 0; i < 800; i++) begin
            bus.iIF_IMEM_Addr   = AW'($urandom_range(0, DEPTH - 1));
            bus.iLoad_Valid     = 1'($urandom_range(0, 1));
            bus.iLoad_Data      = W'($urandom);
            bus.iLoad_Start     = ($urandom_range(0, 7) == 0);
            bus.iLoad_Base_Addr = AW'($urandom_range(0, DEPTH - 1));
            bus.iLoad_Count     = CW'($urandom_range(0, 8));
            step();
        end
        bus.iLoad_Start = 1'b0;
        bus.iLoad_Valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
